// File: rtl/bcd3_scan_display.sv
// Three-digit BCD to multiplexed seven-segment driver.
// Digits are snapshotted once per frame, leading zeros can be blanked, and an invalid digit sets a sticky flag.
module bcd3_scan_display #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       ck,
  input  logic       rs,
  input  logic       en,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame,
  output logic       err
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2} slot_t;

  slot_t         r_slot, w_slot_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_s0, r_s1, r_s2;
  logic [2:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame, r_err;

  logic          w_last, w_frame_end, w_blank, w_invalid;
  logic [3:0]    w_digit;
  logic [2:0]    w_an;
  logic [6:0]    w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1111110;
      4'd1:    f_decode = 7'b0110000;
      4'd2:    f_decode = 7'b1101101;
      4'd3:    f_decode = 7'b1111001;
      4'd4:    f_decode = 7'b0110011;
      4'd5:    f_decode = 7'b1011011;
      4'd6:    f_decode = 7'b1011111;
      4'd7:    f_decode = 7'b1110000;
      4'd8:    f_decode = 7'b1111111;
      4'd9:    f_decode = 7'b1111011;
      default: f_decode = 7'b0000001;
    endcase
  endfunction

  assign w_last      = (r_cnt == CNT_MAX);
  assign w_frame_end = w_last && (r_slot == SLOT2);

  // State register: scan position and the frame snapshot.
  always_ff @(posedge ck) begin
    if (!rs) begin
      r_cnt  <= '0;
      r_slot <= SLOT0;
      r_s0   <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_slot <= w_slot_nxt;
      if (en && w_frame_end) begin
        r_s0 <= bcd0;
        r_s1 <= bcd1;
        r_s2 <= bcd2;
      end
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_slot_nxt = r_slot;
    if (en) begin
      if (w_last) begin
        w_cnt_nxt = '0;
        case (r_slot)
          SLOT0:   w_slot_nxt = SLOT1;
          SLOT1:   w_slot_nxt = SLOT2;
          default: w_slot_nxt = SLOT0;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Slot contents from the pre-edge slot; the blank terms only fire on zero digits, so a dash is never hidden.
  always_comb begin
    w_an    = 3'b001;
    w_digit = r_s0;
    w_blank = 1'b0;
    case (r_slot)
      SLOT1: begin
        w_an    = 3'b010;
        w_digit = r_s1;
        w_blank = BLANK_LZ && (r_s2 == 4'd0) && (r_s1 == 4'd0);
      end
      SLOT2: begin
        w_an    = 3'b100;
        w_digit = r_s2;
        w_blank = BLANK_LZ && (r_s2 == 4'd0);
      end
      default: ;
    endcase
    w_invalid = (w_digit > 4'd9);
    w_seg     = w_blank ? '0 : f_decode(w_digit);
  end

  always_ff @(posedge ck) begin
    if (!rs) begin
      r_an    <= '0;
      r_seg   <= '0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else if (en) begin
      r_an    <= w_an;
      r_seg   <= w_seg;
      r_frame <= w_frame_end;
      r_err   <= r_err | w_invalid;
    end else begin
      r_an    <= '0;
      r_seg   <= '0;
      r_frame <= 1'b0;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign frame = r_frame;
  assign err   = r_err;

endmodule
